// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder: gathers a serial unsigned sample stream into an
// INPUTS_NUM-slot window and presents it packed and zero-extended as the
// idata vector of adder_tree. Slot 0 holds the newest sample. win_valid marks
// a new window and sum_valid follows it by TREE_LATENCY clocks so downstream
// logic can qualify the tree output.
// SLIDING=1 gives a moving window; SLIDING=0 gives disjoint blocks.
// Optional feature: define FEEDER_FLUSH_EN to add the flush port, which pads
// and emits a partial block.
module adder_tree_feeder #(
    parameter int INPUTS_NUM   = 7,
    parameter int IDATA_WIDTH  = 16,
    parameter int SAMPLE_WIDTH = 8,
    parameter int TREE_LATENCY = 3,
    parameter int SLIDING      = 1,
    localparam int FW          = $clog2(INPUTS_NUM + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [SAMPLE_WIDTH-1:0]           in_data,
    output logic                              in_ready,
`ifdef FEEDER_FLUSH_EN
    input  logic                              flush,
`endif
    output logic [INPUTS_NUM*IDATA_WIDTH-1:0] win_data,
    output logic                              win_valid,
    output logic                              sum_valid,
    output logic [FW-1:0]                     fill_cnt,
    output logic [15:0]                       win_cnt
);

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [IDATA_WIDTH-1:0]    slot_q [INPUTS_NUM];
    logic [IDATA_WIDTH-1:0]    slot_d [INPUTS_NUM];
    logic [FW-1:0]             fill_q, fill_d;
    logic                      win_valid_q, win_valid_d;
    logic [15:0]               win_cnt_q, win_cnt_d;
    // Set after a partial-block emit: the padded window is shown for one
    // cycle, then every slot is wiped so stale data never leaks into the
    // next block.
    logic                      clr_q, clr_d;
    logic [TREE_LATENCY-1:0]   dly_q, dly_d;
    logic                      flush_w;
    logic                      accept;
    logic [FW-1:0]             fill_inc;

`ifdef FEEDER_FLUSH_EN
    assign flush_w  = flush;
    assign in_ready = ~flush;
`else
    assign flush_w  = 1'b0;
    assign in_ready = 1'b1;
`endif

    assign accept   = in_valid & ~flush_w;
    assign fill_inc = fill_q + 1'b1;
    // The window strobe walks through a plain shift line; bit 0 takes the
    // strobe one clock after it becomes visible.
    assign dly_d    = TREE_LATENCY'({dly_q, win_valid_q});

    // Next-state logic: slot shifting, fill counting, flush handling.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        fill_d      = fill_q;
        win_valid_d = 1'b0;
        win_cnt_d   = win_cnt_q;
        clr_d       = 1'b0;

        if (clr_q) begin
            for (int k = 0; k < INPUTS_NUM; k++) slot_d[k] = '0;
        end

        if (flush_w) begin
            if (state_q == RUN) begin
                for (int k = 0; k < INPUTS_NUM; k++) slot_d[k] = '0;
                fill_d  = '0;
                state_d = FILL;
            end else if (fill_q != '0) begin
                for (int k = 0; k < INPUTS_NUM; k++) begin
                    if (FW'(k) >= fill_q) slot_d[k] = '0;
                end
                win_valid_d = 1'b1;
                win_cnt_d   = win_cnt_q + 16'd1;
                fill_d      = '0;
                clr_d       = 1'b1;
            end
        end else if (accept) begin
            for (int k = INPUTS_NUM - 1; k > 0; k--) slot_d[k] = slot_d[k-1];
            slot_d[0] = IDATA_WIDTH'(in_data);
            if (state_q == RUN) begin
                win_valid_d = 1'b1;
                win_cnt_d   = win_cnt_q + 16'd1;
            end else if (fill_inc == FW'(INPUTS_NUM)) begin
                win_valid_d = 1'b1;
                win_cnt_d   = win_cnt_q + 16'd1;
                if (SLIDING != 0) begin
                    fill_d  = fill_inc;
                    state_d = RUN;
                end else begin
                    fill_d  = '0;
                end
            end else begin
                fill_d = fill_inc;
            end
        end
    end

    // State registers; reset clears the window and the whole strobe delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            slot_q      <= '{default: '0};
            fill_q      <= '0;
            win_valid_q <= 1'b0;
            win_cnt_q   <= '0;
            clr_q       <= 1'b0;
            dly_q       <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            fill_q      <= fill_d;
            win_valid_q <= win_valid_d;
            win_cnt_q   <= win_cnt_d;
            clr_q       <= clr_d;
            dly_q       <= dly_d;
        end
    end

    // Pack the slots into the flat idata layout the tree expects.
    always_comb begin
        win_data = '0;
        for (int k = 0; k < INPUTS_NUM; k++) begin
            win_data[k*IDATA_WIDTH +: IDATA_WIDTH] = slot_q[k];
        end
    end

    assign win_valid = win_valid_q;
    assign sum_valid = dly_q[TREE_LATENCY-1];
    assign fill_cnt  = fill_q;
    assign win_cnt   = win_cnt_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Directed bench for adder_tree_feeder: one sliding-window instance and one
// block-mode instance share clock and reset. Flush scenarios are compiled in
// when FEEDER_FLUSH_EN is defined.
`timescale 1ns/1ps
module tb_adder_tree_feeder;
    localparam int N  = 7;
    localparam int IW = 16;
    localparam int WW = N * IW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          s_valid, s_ready, s_wv, s_sv;
    logic [7:0]    s_data;
    logic [WW-1:0] s_win;
    logic [2:0]    s_fill;
    logic [15:0]   s_cnt;
    logic          b_valid, b_ready, b_wv, b_sv;
    logic [7:0]    b_data;
    logic [WW-1:0] b_win;
    logic [2:0]    b_fill;
    logic [15:0]   b_cnt;
`ifdef FEEDER_FLUSH_EN
    logic          s_flush, b_flush;
`endif

    int checks = 0;
    int errors = 0;

    adder_tree_feeder #(.INPUTS_NUM(N), .IDATA_WIDTH(IW), .SAMPLE_WIDTH(8),
                        .TREE_LATENCY(3), .SLIDING(1)) u_slide (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data), .in_ready(s_ready),
`ifdef FEEDER_FLUSH_EN
        .flush(s_flush),
`endif
        .win_data(s_win), .win_valid(s_wv), .sum_valid(s_sv),
        .fill_cnt(s_fill), .win_cnt(s_cnt)
    );

    adder_tree_feeder #(.INPUTS_NUM(N), .IDATA_WIDTH(IW), .SAMPLE_WIDTH(8),
                        .TREE_LATENCY(3), .SLIDING(0)) u_block (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
`ifdef FEEDER_FLUSH_EN
        .flush(b_flush),
`endif
        .win_data(b_win), .win_valid(b_wv), .sum_valid(b_sv),
        .fill_cnt(b_fill), .win_cnt(b_cnt)
    );

    // Expected window: slot k = (newest-k) mod 256 for k < n, zero above.
    function automatic logic [WW-1:0] mk(input int newest, input int n);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[k*IW +: IW] = IW'((newest - k) & 255);
        return w;
    endfunction

    // Reference adder tree: sum of all slots.
    function automatic int tsum(input logic [WW-1:0] w);
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += int'(w[k*IW +: IW]);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; b_valid = 1'b0; s_data = '0; b_data = '0;
`ifdef FEEDER_FLUSH_EN
        s_flush = 1'b0; b_flush = 1'b0;
`endif
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (s_win !== '0)    begin errors++; $display("FAIL rst_win got=%h exp=0", s_win); end
        checks++; if (s_wv !== 1'b0)   begin errors++; $display("FAIL rst_wv got=%b exp=0", s_wv); end
        checks++; if (s_sv !== 1'b0)   begin errors++; $display("FAIL rst_sv got=%b exp=0", s_sv); end
        checks++; if (s_fill !== 3'd0) begin errors++; $display("FAIL rst_fill got=%0d exp=0", s_fill); end
        checks++; if (s_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", s_cnt); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", s_ready); end
        checks++; if (b_win !== '0)    begin errors++; $display("FAIL rst_bwin got=%h exp=0", b_win); end
    endtask

    task automatic test_sliding_fill();
        for (int i = 1; i <= 7; i++) begin
            s_valid = 1'b1; s_data = 8'(i);
            step();
            if (i < 7) begin
                checks++; if (s_wv !== 1'b0)   begin errors++; $display("FAIL fill_wv_%0d got=%b exp=0", i, s_wv); end
                checks++; if (s_fill !== 3'(i)) begin errors++; $display("FAIL fill_cnt_%0d got=%0d exp=%0d", i, s_fill, i); end
            end
        end
        s_valid = 1'b0;
        checks++; if (s_wv !== 1'b1)      begin errors++; $display("FAIL t1_wv got=%b exp=1", s_wv); end
        checks++; if (s_win !== mk(7, 7)) begin errors++; $display("FAIL t1_win got=%h exp=%h", s_win, mk(7, 7)); end
        checks++; if (tsum(s_win) !== 28) begin errors++; $display("FAIL t1_sum got=%0d exp=28", tsum(s_win)); end
        checks++; if (s_fill !== 3'd7)    begin errors++; $display("FAIL t1_fill got=%0d exp=7", s_fill); end
        checks++; if (s_cnt !== 16'd1)    begin errors++; $display("FAIL t1_cnt got=%0d exp=1", s_cnt); end
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++; if (s_sv !== (c == 3)) begin errors++; $display("FAIL t1_sv_c%0d got=%b exp=%b", c, s_sv, (c == 3)); end
        end
        checks++; if (s_wv !== 1'b0)      begin errors++; $display("FAIL t1_stall_wv got=%b exp=0", s_wv); end
        checks++; if (s_win !== mk(7, 7)) begin errors++; $display("FAIL t1_hold_win got=%h exp=%h", s_win, mk(7, 7)); end
    endtask

    task automatic test_sliding_next();
        s_valid = 1'b1; s_data = 8'd8;
        step();
        s_valid = 1'b0;
        checks++; if (s_wv !== 1'b1)      begin errors++; $display("FAIL t2_wv got=%b exp=1", s_wv); end
        checks++; if (s_win !== mk(8, 7)) begin errors++; $display("FAIL t2_win got=%h exp=%h", s_win, mk(8, 7)); end
        checks++; if (tsum(s_win) !== 35) begin errors++; $display("FAIL t2_sum got=%0d exp=35", tsum(s_win)); end
        checks++; if (s_cnt !== 16'd2)    begin errors++; $display("FAIL t2_cnt got=%0d exp=2", s_cnt); end
        step();
        checks++; if (s_wv !== 1'b0)      begin errors++; $display("FAIL t2_gap_wv got=%b exp=0", s_wv); end
    endtask

    task automatic test_block();
        int gaps [14] = '{0, 1, 0, 2, 0, 0, 1, 0, 3, 0, 0, 1, 0, 2};
        int nwv = 0, nsv = 0;
        int sums [2] = '{0, 0};
        for (int i = 1; i <= 14; i++) begin
            for (int g = 0; g < gaps[i-1]; g++) begin
                b_valid = 1'b0;
                step();
                if (b_wv) nwv++;
                if (b_sv) nsv++;
            end
            b_valid = 1'b1; b_data = 8'(i);
            step();
            if (b_wv) begin
                if (nwv < 2) sums[nwv] = tsum(b_win);
                nwv++;
            end
            if (b_sv) nsv++;
            if (i == 7) begin
                checks++; if (b_fill !== 3'd0) begin errors++; $display("FAIL t3_fill7 got=%0d exp=0", b_fill); end
            end
        end
        b_valid = 1'b0;
        checks++; if (b_win !== mk(14, 7)) begin errors++; $display("FAIL t3_win got=%h exp=%h", b_win, mk(14, 7)); end
        for (int c = 0; c < 5; c++) begin
            step();
            if (b_wv) nwv++;
            if (b_sv) nsv++;
        end
        checks++; if (nwv !== 2)       begin errors++; $display("FAIL t3_nwv got=%0d exp=2", nwv); end
        checks++; if (sums[0] !== 28)  begin errors++; $display("FAIL t3_sum0 got=%0d exp=28", sums[0]); end
        checks++; if (sums[1] !== 77)  begin errors++; $display("FAIL t3_sum1 got=%0d exp=77", sums[1]); end
        checks++; if (nsv !== 2)       begin errors++; $display("FAIL t3_nsv got=%0d exp=2", nsv); end
        checks++; if (b_cnt !== 16'd2) begin errors++; $display("FAIL t3_cnt got=%0d exp=2", b_cnt); end
    endtask

`ifdef FEEDER_FLUSH_EN
    task automatic test_flush();
        for (int i = 5; i <= 7; i++) begin
            b_valid = 1'b1; b_data = 8'(i);
            step();
        end
        b_flush = 1'b1; b_valid = 1'b1; b_data = 8'd9;
        #1;
        checks++; if (b_ready !== 1'b0)   begin errors++; $display("FAIL t4_ready got=%b exp=0", b_ready); end
        step();
        checks++; if (b_wv !== 1'b1)      begin errors++; $display("FAIL t4_wv got=%b exp=1", b_wv); end
        checks++; if (b_win !== mk(7, 3)) begin errors++; $display("FAIL t4_win got=%h exp=%h", b_win, mk(7, 3)); end
        checks++; if (tsum(b_win) !== 18) begin errors++; $display("FAIL t4_sum got=%0d exp=18", tsum(b_win)); end
        checks++; if (b_fill !== 3'd0)    begin errors++; $display("FAIL t4_fill got=%0d exp=0", b_fill); end
        checks++; if (b_cnt !== 16'd3)    begin errors++; $display("FAIL t4_cnt got=%0d exp=3", b_cnt); end
        step();
        checks++; if (b_wv !== 1'b0)      begin errors++; $display("FAIL t4_hold_wv got=%b exp=0", b_wv); end
        checks++; if (b_win !== '0)       begin errors++; $display("FAIL t4_clr_win got=%h exp=0", b_win); end
        checks++; if (b_cnt !== 16'd3)    begin errors++; $display("FAIL t4_hold_cnt got=%0d exp=3", b_cnt); end
        b_flush = 1'b0; b_valid = 1'b0;
        s_flush = 1'b1;
        step();
        s_flush = 1'b0;
        checks++; if (s_wv !== 1'b0)      begin errors++; $display("FAIL run_flush_wv got=%b exp=0", s_wv); end
        checks++; if (s_fill !== 3'd0)    begin errors++; $display("FAIL run_flush_fill got=%0d exp=0", s_fill); end
        checks++; if (s_win !== '0)       begin errors++; $display("FAIL run_flush_win got=%h exp=0", s_win); end
        checks++; if (s_cnt !== 16'd2)    begin errors++; $display("FAIL run_flush_cnt got=%0d exp=2", s_cnt); end
        s_valid = 1'b1; s_data = 8'd3;
        step();
        s_valid = 1'b0;
        checks++; if (s_wv !== 1'b0)      begin errors++; $display("FAIL refill_wv got=%b exp=0", s_wv); end
        checks++; if (s_fill !== 3'd1)    begin errors++; $display("FAIL refill_fill got=%0d exp=1", s_fill); end
        checks++; if (s_win !== mk(3, 1)) begin errors++; $display("FAIL refill_win got=%h exp=%h", s_win, mk(3, 1)); end
    endtask
`endif

    task automatic test_reset_mid();
        logic saw_sv;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1; s_data = 8'(i);
            step();
        end
        s_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (s_fill !== 3'd0) begin errors++; $display("FAIL t5a_fill got=%0d exp=0", s_fill); end
        checks++; if (s_win !== '0)    begin errors++; $display("FAIL t5a_win got=%h exp=0", s_win); end
        for (int i = 1; i <= 7; i++) begin
            s_valid = 1'b1; s_data = 8'(i);
            step();
        end
        s_valid = 1'b0;
        checks++; if (s_wv !== 1'b1)   begin errors++; $display("FAIL t5b_pre_wv got=%b exp=1", s_wv); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (s_wv !== 1'b0)   begin errors++; $display("FAIL t5b_wv got=%b exp=0", s_wv); end
        checks++; if (s_win !== '0)    begin errors++; $display("FAIL t5b_win got=%h exp=0", s_win); end
        checks++; if (s_cnt !== 16'd0) begin errors++; $display("FAIL t5b_cnt got=%0d exp=0", s_cnt); end
        checks++; if (s_fill !== 3'd0) begin errors++; $display("FAIL t5b_fill got=%0d exp=0", s_fill); end
        saw_sv = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (s_sv !== 1'b0) saw_sv = 1'b1;
        end
        checks++; if (saw_sv !== 1'b0) begin errors++; $display("FAIL t5b_sv got=%b exp=0", saw_sv); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int j = 1; j <= 65541; j++) begin
            s_valid = 1'b1; s_data = 8'(j & 255);
            step();
        end
        checks++; if (s_cnt !== 16'hFFFF)     begin errors++; $display("FAIL t6_cnt_ffff got=%h exp=ffff", s_cnt); end
        checks++; if (s_fill !== 3'd7)        begin errors++; $display("FAIL t6_fill got=%0d exp=7", s_fill); end
        checks++; if (s_win !== mk(65541, 7)) begin errors++; $display("FAIL t6_win_a got=%h exp=%h", s_win, mk(65541, 7)); end
        s_data = 8'(65542 & 255);
        step();
        s_valid = 1'b0;
        checks++; if (s_cnt !== 16'h0000)     begin errors++; $display("FAIL t6_cnt_wrap got=%h exp=0000", s_cnt); end
        checks++; if (s_wv !== 1'b1)          begin errors++; $display("FAIL t6_wv got=%b exp=1", s_wv); end
        checks++; if (s_win !== mk(65542, 7)) begin errors++; $display("FAIL t6_win_b got=%h exp=%h", s_win, mk(65542, 7)); end
        step();
        checks++; if (s_wv !== 1'b0)          begin errors++; $display("FAIL t6_idle_wv got=%b exp=0", s_wv); end
        checks++; if (s_cnt !== 16'h0000)     begin errors++; $display("FAIL t6_idle_cnt got=%h exp=0000", s_cnt); end
    endtask

    initial begin
        test_reset();
        test_sliding_fill();
        test_sliding_next();
        test_block();
`ifdef FEEDER_FLUSH_EN
        test_flush();
`endif
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
